// File: rtl/rconst_seq.sv
// Keccak round-constant sequencer.
// Produces RPC compressed round constants per group (7 bits per round, the
// only RC bits that can be nonzero: 0,1,3,7,15,31,63) from the 8-bit rc(t)
// LFSR x^8+x^6+x^5+x^4+1, stepping 7*RPC times per accepted group.
module rconst_seq #(
    parameter int unsigned RPC = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               mode,
    input  logic               abort,
    input  logic               advance,
    output logic [7*RPC-1:0]   rc_out,
    output logic               rc_valid,
    output logic [4:0]         round_idx,
    output logic               last,
    output logic               busy,
    output logic               done
);

    localparam int unsigned LW = 7 * RPC;

    if (!(RPC == 1 || RPC == 2 || RPC == 3 || RPC == 4 || RPC == 6)) begin : g_bad_rpc
        $fatal(1, "rconst_seq: RPC must be one of 1, 2, 3, 4, 6");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // One step of the rc(t) LFSR; bit 0 is the output bit rc(t).
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int unsigned n);
        logic [7:0] st;
        st = s;
        for (int unsigned i = 0; i < n; i++) begin
            st = lfsr_step(st);
        end
        return st;
    endfunction

    // Output bits of the next LW steps: bit 7k+j is rc[j] of lane k.
    function automatic logic [LW-1:0] lanes(input logic [7:0] s);
        logic [7:0]    st;
        logic [LW-1:0] l;
        st = s;
        l  = '0;
        for (int unsigned i = 0; i < LW; i++) begin
            l[i] = st[0];
            st   = lfsr_step(st);
        end
        return l;
    endfunction

    localparam logic [7:0]    LFSR_INIT = 8'h01;
    localparam logic [7:0]    START_M1  = lfsr_adv(LFSR_INIT, 84);
    localparam logic [LW-1:0] LANES_M0  = lanes(LFSR_INIT);
    localparam logic [LW-1:0] LANES_M1  = lanes(START_M1);
    localparam logic [4:0]    STEP      = 5'(RPC);
    localparam logic          LAST_M0   = (RPC == 24);
    localparam logic          LAST_M1   = (12 + RPC == 24);

    state_t        r_state;
    logic [7:0]    r_lfsr;
    logic [LW-1:0] r_rc_out;
    logic          r_valid;
    logic [4:0]    r_round;
    logic          r_last;
    logic          r_done;

    logic [7:0]    w_lfsr_next;
    logic [LW-1:0] w_lanes_next;
    logic [4:0]    w_idx_next;
    logic          w_last_next;

    // Next-group LFSR state and its lanes, fully unrolled.
    always_comb begin
        w_lfsr_next  = lfsr_adv(r_lfsr, LW);
        w_lanes_next = lanes(w_lfsr_next);
        w_idx_next   = r_round + STEP;
        w_last_next  = ((w_idx_next + STEP) == 5'd24);
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_lfsr   <= LFSR_INIT;
            r_rc_out <= '0;
            r_valid  <= 1'b0;
            r_round  <= '0;
            r_last   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!abort && start) begin
                        r_state  <= RUN;
                        r_lfsr   <= mode ? START_M1 : LFSR_INIT;
                        r_rc_out <= mode ? LANES_M1 : LANES_M0;
                        r_round  <= mode ? 5'd12 : 5'd0;
                        r_last   <= mode ? LAST_M1 : LAST_M0;
                        r_valid  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort || (advance && r_last)) begin
                        r_state  <= IDLE;
                        r_rc_out <= '0;
                        r_valid  <= 1'b0;
                        r_round  <= '0;
                        r_last   <= 1'b0;
                        r_done   <= !abort;
                    end else if (advance) begin
                        r_lfsr   <= w_lfsr_next;
                        r_rc_out <= w_lanes_next;
                        r_round  <= w_idx_next;
                        r_last   <= w_last_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rc_out    = r_rc_out;
    assign rc_valid  = r_valid;
    assign round_idx = r_round;
    assign last      = r_last;
    assign busy      = (r_state == RUN);
    assign done      = r_done;

endmodule

// File: tb/tb_rconst_seq.sv
// Self-checking bench for rconst_seq: one instance per legal RPC, expected
// groups taken from the FIPS 202 round-constant table compressed to 7 bits.
module tb_rconst_seq;

    localparam int unsigned NDUT = 5;
    localparam int unsigned RPCS [NDUT] = '{1, 2, 3, 4, 6};

    // FIPS 202 RC[0..23], bits 0,1,3,7,15,31,63 packed into bits 0..6.
    localparam logic [6:0] TAB [24] = '{
        7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
        7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
        7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
    };

    typedef struct packed {
        logic [41:0] rc;
        logic [4:0]  ridx;
        logic        lst;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start_v   [NDUT];
    logic        mode_v    [NDUT];
    logic        abort_v   [NDUT];
    logic        advance_v [NDUT];
    logic [41:0] rc_v      [NDUT];
    logic        rcvalid_v [NDUT];
    logic [4:0]  ridx_v    [NDUT];
    logic        last_v    [NDUT];
    logic        busy_v    [NDUT];
    logic        done_v    [NDUT];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    exp_t        sbq [$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [7*RPCS[g]-1:0] w_rc;
        rconst_seq #(.RPC(RPCS[g])) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .start     (start_v[g]),
            .mode      (mode_v[g]),
            .abort     (abort_v[g]),
            .advance   (advance_v[g]),
            .rc_out    (w_rc),
            .rc_valid  (rcvalid_v[g]),
            .round_idx (ridx_v[g]),
            .last      (last_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g])
        );
        assign rc_v[g] = 42'(w_rc);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input int unsigned rpc, input int unsigned r);
        exp_t e;
        e = '0;
        for (int unsigned k = 0; k < rpc; k++) begin
            e.rc[7*k +: 7] = TAB[r + k];
        end
        e.ridx = 5'(r);
        e.lst  = (r + rpc == 24);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int unsigned d, input string tag);
        chk({tag, "_rc_out"},   64'(rc_v[d]),      64'd0);
        chk({tag, "_rc_valid"}, 64'(rcvalid_v[d]), 64'd0);
        chk({tag, "_round"},    64'(ridx_v[d]),    64'd0);
        chk({tag, "_last"},     64'(last_v[d]),    64'd0);
        chk({tag, "_busy"},     64'(busy_v[d]),    64'd0);
        chk({tag, "_done"},     64'(done_v[d]),    64'd0);
    endtask

    task automatic chk_idle(input int unsigned d, input string tag);
        chk({tag, "_rc_out"},   64'(rc_v[d]),      64'd0);
        chk({tag, "_rc_valid"}, 64'(rcvalid_v[d]), 64'd0);
        chk({tag, "_last"},     64'(last_v[d]),    64'd0);
        chk({tag, "_busy"},     64'(busy_v[d]),    64'd0);
    endtask

    // Wait one cycle, then compare the visible group with the scoreboard head.
    task automatic cyc_check(input int unsigned d, input string tag);
        exp_t e;
        @(negedge clk);
        e = (sbq.size() != 0) ? sbq[0] : '0;
        chk({tag, "_rc_valid"}, 64'(rcvalid_v[d]), 64'd1);
        chk({tag, "_busy"},     64'(busy_v[d]),    64'd1);
        chk({tag, "_rc_out"},   64'(rc_v[d]),      64'(e.rc));
        chk({tag, "_round"},    64'(ridx_v[d]),    64'(e.ridx));
        chk({tag, "_last"},     64'(last_v[d]),    64'(e.lst));
    endtask

    // Called when advance=1 is driven into the coming edge on a valid group.
    task automatic accept(input int unsigned d);
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            if (!e.lst) sbq.push_back(mk_exp(RPCS[d], int'(e.ridx) + RPCS[d]));
        end
    endtask

    task automatic run_full(input int unsigned d, input logic m);
        int unsigned rpc;
        int unsigned ng;
        string       tag;
        rpc = RPCS[d];
        ng  = (m ? 12 : 24) / rpc;
        tag = $sformatf("sweep_rpc%0d_m%0d", rpc, m);
        @(negedge clk);
        start_v[d]   = 1'b1;
        mode_v[d]    = m;
        advance_v[d] = 1'b1;
        sbq.delete();
        sbq.push_back(mk_exp(rpc, m ? 12 : 0));
        for (int unsigned g = 0; g < ng; g++) begin
            cyc_check(d, $sformatf("%s_g%0d", tag, g));
            if (g == 0) begin
                start_v[d] = 1'b0;
                mode_v[d]  = ~m;
            end
            accept(d);
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done_v[d]), 64'd1);
        chk_idle(d, {tag, "_after"});
        advance_v[d] = 1'b0;
        mode_v[d]    = 1'b0;
        @(negedge clk);
        chk({tag, "_done_clear"}, 64'(done_v[d]), 64'd0);
    endtask

    initial begin
        reset_n = 1'b1;
        for (int i = 0; i < int'(NDUT); i++) begin
            start_v[i]   = 1'b0;
            mode_v[i]    = 1'b0;
            abort_v[i]   = 1'b0;
            advance_v[i] = 1'b0;
        end
        #1 reset_n = 1'b0;
        #1;
        for (int unsigned i = 0; i < NDUT; i++) chk_reset(i, $sformatf("reset_d%0d", i));
        @(negedge clk);
        reset_n = 1'b1;

        // advance in IDLE does nothing
        advance_v[1] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle(1, "idle_advance");
        end
        advance_v[1] = 1'b0;

        // abort and start together in IDLE: start dropped
        abort_v[1] = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        chk_idle(1, "abort_start_idle");
        abort_v[1] = 1'b0;
        start_v[1] = 1'b0;
        @(negedge clk);
        chk_idle(1, "abort_start_idle2");

        // every RPC, both modes, advance held high
        for (int unsigned d = 0; d < NDUT; d++) begin
            run_full(d, 1'b0);
            run_full(d, 1'b1);
        end

        // RPC=2: hold at round 4, ignored start at 6, abort at 8
        @(negedge clk);
        sbq.delete();
        start_v[1]   = 1'b1;
        mode_v[1]    = 1'b0;
        sbq.push_back(mk_exp(2, 0));
        cyc_check(1, "ctl_g0");
        start_v[1]   = 1'b0;
        advance_v[1] = 1'b1;
        accept(1);
        cyc_check(1, "ctl_g2");
        accept(1);
        cyc_check(1, "ctl_g4");
        advance_v[1] = 1'b0;
        for (int i = 0; i < 5; i++) cyc_check(1, $sformatf("hold_r4_c%0d", i));
        advance_v[1] = 1'b1;
        accept(1);
        cyc_check(1, "ctl_g6");
        start_v[1]   = 1'b1;
        advance_v[1] = 1'b0;
        cyc_check(1, "start_in_run_r6");
        start_v[1]   = 1'b0;
        advance_v[1] = 1'b1;
        accept(1);
        cyc_check(1, "ctl_g8");
        abort_v[1]   = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk_idle(1, "abort_r8");
        chk("abort_r8_done", 64'(done_v[1]), 64'd0);
        abort_v[1]   = 1'b0;
        advance_v[1] = 1'b0;
        @(negedge clk);
        chk_idle(1, "abort_r8_stay");
        chk("abort_r8_done2", 64'(done_v[1]), 64'd0);

        // asynchronous reset mid-sequence at round 10
        start_v[1]   = 1'b1;
        advance_v[1] = 1'b1;
        sbq.push_back(mk_exp(2, 0));
        cyc_check(1, "rst_g0");
        start_v[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            accept(1);
            cyc_check(1, $sformatf("rst_g%0d", 2 * (i + 1)));
        end
        advance_v[1] = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_reset(1, "async_reset_r10");
        sbq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle(1, "post_reset_wait");
        start_v[1] = 1'b1;
        sbq.push_back(mk_exp(2, 0));
        cyc_check(1, "post_reset_g0");
        start_v[1] = 1'b0;
        abort_v[1] = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk_idle(1, "final_abort");
        chk("final_abort_done", 64'(done_v[1]), 64'd0);
        abort_v[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
